// File: rtl/myadd_pkg.sv
// Shared constants and helpers for the registered AND unit.
package myadd_pkg;

  localparam int unsigned DEF_WIDTH = 32'd1;
  localparam int unsigned DEF_CNT_W = 32'd8;

  localparam logic [1:0] COMBO_00 = 2'd0;
  localparam logic [1:0] COMBO_01 = 2'd1;
  localparam logic [1:0] COMBO_10 = 2'd2;
  localparam logic [1:0] COMBO_11 = 2'd3;

  // One-hot coverage bit for the {a0,b0} input combination.
  function automatic logic [3:0] combo_onehot(input logic a0, input logic b0);
    logic [3:0] onehot;
    case ({a0, b0})
      COMBO_00: onehot = 4'b0001;
      COMBO_01: onehot = 4'b0010;
      COMBO_10: onehot = 4'b0100;
      COMBO_11: onehot = 4'b1000;
      default:  onehot = 4'b0000;
    endcase
    return onehot;
  endfunction

endpackage

// File: rtl/myadd_and_unit_sat_counter.sv
// Saturating up-counter with synchronous clear taking priority over increment.
module sat_counter #(
  parameter int unsigned W = 32'd8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_r;
  logic         at_max_s;

  assign at_max_s = (count_r == {W{1'b1}});

  // Counter state: clear wins, increment stops at the all-ones value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= {W{1'b0}};
    end else if (clr) begin
      count_r <= {W{1'b0}};
    end else if (inc && !at_max_s) begin
      count_r <= count_r + {{(W-1){1'b0}}, 1'b1};
    end else begin
      count_r <= count_r;
    end
  end

  assign count = count_r;

endmodule

// File: rtl/myadd_and_unit.sv
// Registered, valid-qualified bitwise AND with all-ones hit counting
// and {a[0],b[0]} input-combination coverage.
module myadd_and_unit
  import myadd_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             stat_clr,
  output logic [WIDTH-1:0] f,
  output logic             out_valid,
  output logic [CNT_W-1:0] hit_count,
  output logic [3:0]       combo_seen,
  output logic             all_seen
);

  logic [WIDTH-1:0] and_s;
  logic             hit_inc_s;
  logic [WIDTH-1:0] f_r;
  logic             out_valid_r;
  logic [3:0]       combo_r;

  assign and_s     = a & b;
  assign hit_inc_s = in_valid & (&and_s);

  // Result register: loads on accepted samples, holds otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f_r         <= {WIDTH{1'b0}};
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= in_valid;
      if (in_valid) begin
        f_r <= and_s;
      end else begin
        f_r <= f_r;
      end
    end
  end

  // Sticky coverage bitmap; a clear discards the same-edge sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      combo_r <= 4'b0000;
    end else if (stat_clr) begin
      combo_r <= 4'b0000;
    end else if (in_valid) begin
      combo_r <= combo_r | combo_onehot(a[0], b[0]);
    end else begin
      combo_r <= combo_r;
    end
  end

  sat_counter #(
    .W (CNT_W)
  ) u_hit_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (stat_clr),
    .inc   (hit_inc_s),
    .count (hit_count)
  );

  assign f          = f_r;
  assign out_valid  = out_valid_r;
  assign combo_seen = combo_r;
  assign all_seen   = &combo_r;

endmodule

// File: tb/tb_myadd_and_unit.sv
// Scoreboard bench: a 1-bit unit with a 2-bit counter and a 4-bit wide unit.
module tb_myadd_and_unit;

  typedef struct {
    logic [3:0] f;
    logic [7:0] hit;
    logic [3:0] combo;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       v1, c1, ov1, all1;
  logic [0:0] a1, b1, f1;
  logic [1:0] hit1;
  logic [3:0] combo1;
  logic       v4, c4, ov4, all4;
  logic [3:0] a4, b4, f4;
  logic [7:0] hit4;
  logic [3:0] combo4;

  int n_cmp = 0;
  int n_err = 0;
  exp_t q1[$];
  exp_t q4[$];

  myadd_and_unit #(.WIDTH(1), .CNT_W(2)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(v1), .a(a1), .b(b1), .stat_clr(c1),
    .f(f1), .out_valid(ov1), .hit_count(hit1), .combo_seen(combo1), .all_seen(all1)
  );

  myadd_and_unit #(.WIDTH(4), .CNT_W(8)) u4 (
    .clk(clk), .rst_n(rst_n), .in_valid(v4), .a(a4), .b(b4), .stat_clr(c4),
    .f(f4), .out_valid(ov4), .hit_count(hit4), .combo_seen(combo4), .all_seen(all4)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor for the 1-bit unit: every out_valid pops one expectation.
  always @(negedge clk) begin : mon1
    exp_t e;
    if (rst_n === 1'b1 && ov1 === 1'b1) begin
      if (q1.size() == 0) begin
        chk("u1_unexpected_valid", {31'd0, ov1}, 32'd0);
      end else begin
        e = q1.pop_front();
        chk("u1_f", {31'd0, f1}, {28'd0, e.f});
        chk("u1_hit", {30'd0, hit1}, {24'd0, e.hit});
        chk("u1_combo", {28'd0, combo1}, {28'd0, e.combo});
      end
    end
  end

  // Monitor for the 4-bit unit.
  always @(negedge clk) begin : mon4
    exp_t e;
    if (rst_n === 1'b1 && ov4 === 1'b1) begin
      if (q4.size() == 0) begin
        chk("u4_unexpected_valid", {31'd0, ov4}, 32'd0);
      end else begin
        e = q4.pop_front();
        chk("u4_f", {28'd0, f4}, {28'd0, e.f});
        chk("u4_hit", {24'd0, hit4}, {24'd0, e.hit});
        chk("u4_combo", {28'd0, combo4}, {28'd0, e.combo});
      end
    end
  end

  task automatic send1(input logic a, input logic b, input logic clr,
                       input logic ef, input logic [1:0] ehit, input logic [3:0] ecombo);
    exp_t e;
    v1 = 1'b1; a1 = a; b1 = b; c1 = clr;
    e.f = {3'd0, ef}; e.hit = {6'd0, ehit}; e.combo = ecombo;
    q1.push_back(e);
    @(negedge clk);
    v1 = 1'b0; c1 = 1'b0;
  endtask

  task automatic send4(input logic [3:0] a, input logic [3:0] b,
                       input logic [3:0] ef, input logic [7:0] ehit, input logic [3:0] ecombo);
    exp_t e;
    v4 = 1'b1; a4 = a; b4 = b;
    e.f = ef; e.hit = ehit; e.combo = ecombo;
    q4.push_back(e);
    @(negedge clk);
    v4 = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    v1 = 1'b1; a1 = 1'b1; b1 = 1'b1; c1 = 1'b0;
    v4 = 1'b1; a4 = 4'hF; b4 = 4'hF; c4 = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_u1_f", {31'd0, f1}, 32'd0);
    chk("rst_u1_out_valid", {31'd0, ov1}, 32'd0);
    chk("rst_u1_hit", {30'd0, hit1}, 32'd0);
    chk("rst_u1_combo", {28'd0, combo1}, 32'd0);
    chk("rst_u1_all_seen", {31'd0, all1}, 32'd0);
    chk("rst_u4_f", {28'd0, f4}, 32'd0);
    chk("rst_u4_hit", {24'd0, hit4}, 32'd0);
    v1 = 1'b0; v4 = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);

    // Truth table, pulses ten cycles apart.
    send1(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0001); repeat (9) @(negedge clk);
    send1(1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 4'b0011); repeat (9) @(negedge clk);
    send1(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0111); repeat (9) @(negedge clk);
    send1(1'b1, 1'b1, 1'b0, 1'b1, 2'd1, 4'b1111); repeat (9) @(negedge clk);
    chk("tt_all_seen", {31'd0, all1}, 32'd1);
    chk("tt_hit", {30'd0, hit1}, 32'd1);

    // Qualifier: operands move with in_valid low.
    a1 = 1'b0; b1 = 1'b0;
    repeat (3) @(negedge clk);
    a1 = 1'b1; b1 = 1'b0;
    repeat (2) @(negedge clk);
    chk("qual_f_hold", {31'd0, f1}, 32'd1);
    chk("qual_out_valid", {31'd0, ov1}, 32'd0);
    chk("qual_hit", {30'd0, hit1}, 32'd1);
    chk("qual_combo", {28'd0, combo1}, 32'hF);

    // Clear on the same edge as an all-ones sample.
    send1(1'b1, 1'b1, 1'b1, 1'b1, 2'd0, 4'b0000);
    repeat (2) @(negedge clk);

    // Saturation, back to back.
    send1(1'b1, 1'b1, 1'b0, 1'b1, 2'd1, 4'b1000);
    send1(1'b1, 1'b1, 1'b0, 1'b1, 2'd2, 4'b1000);
    send1(1'b1, 1'b1, 1'b0, 1'b1, 2'd3, 4'b1000);
    send1(1'b1, 1'b1, 1'b0, 1'b1, 2'd3, 4'b1000);
    send1(1'b1, 1'b1, 1'b0, 1'b1, 2'd3, 4'b1000);
    repeat (2) @(negedge clk);
    chk("sat_hold", {30'd0, hit1}, 32'd3);

    // Clear alone leaves the result path untouched.
    c1 = 1'b1;
    @(negedge clk);
    c1 = 1'b0;
    chk("clr_hit", {30'd0, hit1}, 32'd0);
    chk("clr_combo", {28'd0, combo1}, 32'd0);
    chk("clr_f", {31'd0, f1}, 32'd1);

    // Reset in the middle of an accepted sample.
    v1 = 1'b1; a1 = 1'b0; b1 = 1'b1;
    #2 rst_n = 1'b0;
    #10 v1 = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("midrst_f", {31'd0, f1}, 32'd0);
    chk("midrst_out_valid", {31'd0, ov1}, 32'd0);
    chk("midrst_combo", {28'd0, combo1}, 32'd0);

    // Wide operands.
    send4(4'b1011, 4'b1110, 4'b1010, 8'd0, 4'b0100);
    send4(4'b1111, 4'b1111, 4'b1111, 8'd1, 4'b1100);
    repeat (3) @(negedge clk);
    chk("wide_all_seen", {31'd0, all4}, 32'd0);
    chk("wide_f_hold", {28'd0, f4}, 32'hF);

    chk("u1_queue_drained", q1.size(), 32'd0);
    chk("u4_queue_drained", q4.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
